// File: rtl/rv32i_insn_encoder.sv
// RV32I instruction encoder: field-level requests in, encoded 32-bit words out through a FIFO.
// LI is split into LUI (+ ADDI when the low part is non-zero) by a two-state FSM.
module rv32i_insn_encoder #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_kind,
   input  logic [2:0]  req_funct3,
   input  logic        req_alt,
   input  logic [4:0]  req_rd,
   input  logic [4:0]  req_rs1,
   input  logic [4:0]  req_rs2,
   input  logic [31:0] req_imm,
   output logic        insn_valid,
   input  logic        insn_ready,
   output logic [31:0] insn_data,
   output logic        insn_illegal
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;

   // Sign-extension range masks: the masked bits must be all zeros or all ones.
   localparam logic [31:0] M_I = 32'hFFFF_F800;
   localparam logic [31:0] M_B = 32'hFFFF_F000;
   localparam logic [31:0] M_J = 32'hFFF0_0000;

   typedef enum logic [0:0] {IDLE = 1'b0, LI2 = 1'b1} state_e;

   function automatic logic all_same(input logic [31:0] v, input logic [31:0] m);
      return ((v & m) == 32'h0) || ((v & m) == m);
   endfunction

   // Returns {illegal, word}; for LI the word is the first instruction of the expansion.
   function automatic logic [32:0] encode(input logic [3:0] kind, input logic [2:0] f3,
                                          input logic alt, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [31:0] imm);
      logic        bad;
      logic        alt_ok;
      logic [31:0] w;
      logic [31:0] sum;
      bad    = 1'b0;
      w      = 32'h0;
      sum    = imm + 32'h0000_0800;
      alt_ok = ((kind == 4'd8) && ((f3 == 3'd0) || (f3 == 3'd5))) ||
               ((kind == 4'd7) && (f3 == 3'd5));
      case (kind)
         4'd0: begin bad = (imm[11:0] != 12'h000); w = {imm[31:12], rd, OP_LUI}; end
         4'd1: begin bad = (imm[11:0] != 12'h000); w = {imm[31:12], rd, OP_AUIPC}; end
         4'd2: begin
            bad = imm[0] || !all_same(imm, M_J);
            w   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
         end
         4'd3: begin
            bad = (f3 != 3'd0) || !all_same(imm, M_I);
            w   = {imm[11:0], rs1, 3'd0, rd, OP_JALR};
         end
         4'd4: begin
            bad = (f3 == 3'd2) || (f3 == 3'd3) || imm[0] || !all_same(imm, M_B);
            w   = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BR};
         end
         4'd5: begin
            bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || !all_same(imm, M_I);
            w   = {imm[11:0], rs1, f3, rd, OP_LOAD};
         end
         4'd6: begin
            bad = (f3 > 3'd2) || !all_same(imm, M_I);
            w   = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
         end
         4'd7: begin
            if ((f3 == 3'd1) || (f3 == 3'd5)) begin
               bad = (imm[31:5] != 27'd0);
               w   = {1'b0, alt, 5'd0, imm[4:0], rs1, f3, rd, OP_IMM};
            end else begin
               bad = !all_same(imm, M_I);
               w   = {imm[11:0], rs1, f3, rd, OP_IMM};
            end
         end
         4'd8: w = {1'b0, alt, 5'd0, rs2, rs1, f3, rd, OP_REG};
         4'd9: begin
            if (all_same(imm, M_I)) begin
               w = {imm[11:0], 5'd0, 3'd0, rd, OP_IMM};
            end else begin
               w = {sum[31:12], rd, OP_LUI};
            end
         end
         default: bad = 1'b1;
      endcase
      if (alt && !alt_ok) begin
         bad = 1'b1;
      end else begin
         bad = bad;
      end
      return bad ? {1'b1, 32'h0} : {1'b0, w};
   endfunction

   state_e            state_q, state_d;
   logic [31:0]       held_q, held_d;
   logic [32:0]       mem_q [DEPTH];
   logic [AW-1:0]     wr_q, rd_q;
   logic [AW:0]       cnt_q, cnt_d;
   logic [32:0]       enc_s, push_word_s, head_s;
   logic              full_s, accept_s, push_s, pop_s, li_split_s;

   assign enc_s       = encode(req_kind, req_funct3, req_alt, req_rd, req_rs1, req_rs2, req_imm);
   assign full_s      = (cnt_q == FULL_CNT);
   assign req_ready   = rst_n && (state_q == IDLE) && !full_s;
   assign accept_s    = req_valid && req_ready;
   assign li_split_s  = (req_kind == 4'd9) && !enc_s[32] && !all_same(req_imm, M_I) &&
                        (req_imm[11:0] != 12'h000);
   assign push_s      = accept_s || ((state_q == LI2) && !full_s);
   assign push_word_s = (state_q == LI2) ? {1'b0, held_q} : enc_s;
   assign insn_valid  = (cnt_q != {(AW+1){1'b0}});
   assign pop_s       = insn_valid && insn_ready;
   assign head_s      = mem_q[rd_q];
   assign insn_data   = insn_valid ? head_s[31:0] : 32'h0;
   assign insn_illegal = insn_valid && head_s[32];

   // Next-state logic: a split LI parks its ADDI in LI2 until the FIFO has room.
   always_comb begin
      state_d = state_q;
      held_d  = held_q;
      case (state_q)
         IDLE: begin
            if (accept_s && li_split_s) begin
               state_d = LI2;
               held_d  = {req_imm[11:0], req_rd, 3'd0, req_rd, OP_IMM};
            end else begin
               state_d = IDLE;
            end
         end
         LI2: begin
            if (!full_s) begin
               state_d = IDLE;
            end else begin
               state_d = LI2;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FIFO occupancy update
   always_comb begin
      cnt_d = cnt_q;
      if (push_s && !pop_s) begin
         cnt_d = cnt_q + (AW+1)'(1);
      end else if (pop_s && !push_s) begin
         cnt_d = cnt_q - (AW+1)'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // FSM state and held ADDI word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         held_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         held_q  <= held_d;
      end
   end

   // FIFO storage and pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 33'h0;
         end
         wr_q  <= {AW{1'b0}};
         rd_q  <= {AW{1'b0}};
         cnt_q <= {(AW+1){1'b0}};
      end else begin
         if (push_s) begin
            mem_q[wr_q] <= push_word_s;
            wr_q        <= wr_q + AW'(1);
         end
         if (pop_s) begin
            rd_q <= rd_q + AW'(1);
         end
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: tb/tb_rv32i_insn_encoder.sv
// Randomized self-checking bench for rv32i_insn_encoder with a range-based reference model.
module tb_rv32i_insn_encoder;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_kind = 4'd0;
   logic [2:0]  req_funct3 = 3'd0;
   logic        req_alt = 1'b0;
   logic [4:0]  req_rd = 5'd0, req_rs1 = 5'd0, req_rs2 = 5'd0;
   logic [31:0] req_imm = 32'd0;
   logic        insn_valid;
   logic        insn_ready = 1'b0;
   logic [31:0] insn_data;
   logic        insn_illegal;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [32:0] expq[$];
   bit          pend = 1'b0;

   rv32i_insn_encoder #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_kind(req_kind), .req_funct3(req_funct3), .req_alt(req_alt),
      .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
      .insn_valid(insn_valid), .insn_ready(insn_ready), .insn_data(insn_data),
      .insn_illegal(insn_illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [32:0] m_enc(input logic [31:0] kind, input logic [31:0] f3,
                                         input logic alt, input logic [31:0] rd,
                                         input logic [31:0] rs1, input logic [31:0] rs2,
                                         input logic [31:0] imm);
      int          s;
      bit          ok, i_ok;
      logic [31:0] w, ifld;
      s    = int'($signed(imm));
      i_ok = (s >= -2048) && (s <= 2047);
      ifld = (imm & 32'hFFF) << 20;
      ok   = 1'b1;
      w    = 32'd0;
      if (alt && !((kind == 32'd8 && (f3 == 32'd0 || f3 == 32'd5)) ||
                   (kind == 32'd7 && f3 == 32'd5))) ok = 1'b0;
      case (kind)
         32'd0, 32'd1: begin
            if (imm % 32'd4096 != 32'd0) ok = 1'b0;
            w = imm + (rd << 7) + ((kind == 32'd0) ? 32'h37 : 32'h17);
         end
         32'd2: begin
            if (imm[0] || s < -(1 << 20) || s >= (1 << 20)) ok = 1'b0;
            w = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'hFF) << 12) |
                (rd << 7) | 32'h6F;
         end
         32'd3: begin
            if (f3 != 32'd0 || !i_ok) ok = 1'b0;
            w = ifld | (rs1 << 15) | (rd << 7) | 32'h67;
         end
         32'd4: begin
            if (f3 == 32'd2 || f3 == 32'd3 || imm[0] || s < -4096 || s > 4095) ok = 1'b0;
            w = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'd63) << 25) | (rs2 << 20) |
                (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'd15) << 8) |
                (((imm >> 11) & 32'd1) << 7) | 32'h63;
         end
         32'd5: begin
            if (f3 == 32'd3 || f3 == 32'd6 || f3 == 32'd7 || !i_ok) ok = 1'b0;
            w = ifld | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
         end
         32'd6: begin
            if (f3 > 32'd2 || !i_ok) ok = 1'b0;
            w = (((imm >> 5) & 32'd127) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
                ((imm & 32'd31) << 7) | 32'h23;
         end
         32'd7: begin
            if (f3 == 32'd1 || f3 == 32'd5) begin
               if (imm >= 32'd32) ok = 1'b0;
               w = (alt ? 32'h4000_0000 : 32'd0) | (imm << 20) | (rs1 << 15) | (f3 << 12) |
                   (rd << 7) | 32'h13;
            end else begin
               if (!i_ok) ok = 1'b0;
               w = ifld | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
            end
         end
         32'd8: w = (alt ? 32'h4000_0000 : 32'd0) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
                    (rd << 7) | 32'h33;
         default: ok = 1'b0;
      endcase
      return ok ? {1'b0, w} : {1'b1, 32'd0};
   endfunction

   task automatic m_li(input logic [31:0] rd, input logic [31:0] imm,
                       output logic [31:0] w0, output logic [31:0] w1, output bit two);
      int s, lo;
      s   = int'($signed(imm));
      lo  = int'($signed(imm << 20)) >>> 20;
      two = 1'b0;
      w1  = 32'd0;
      if (s >= -2048 && s <= 2047) begin
         w0 = ((imm & 32'hFFF) << 20) | (rd << 7) | 32'h13;
      end else begin
         // upper part is whatever remains after the sign-extended ADDI adds lo back
         w0 = (imm - 32'(lo)) | (rd << 7) | 32'h37;
         if (lo != 0) begin
            two = 1'b1;
            w1  = ((imm & 32'hFFF) << 20) | (rd << 15) | (rd << 7) | 32'h13;
         end
      end
   endtask

   task automatic m_accept();
      logic [31:0] w0, w1;
      bit          two;
      if (req_kind == 4'd9 && !req_alt) begin
         m_li(32'(req_rd), req_imm, w0, w1, two);
         expq.push_back({1'b0, w0});
         if (two) begin
            expq.push_back({1'b0, w1});
            pend = 1'b1;
         end
      end else begin
         expq.push_back(m_enc(32'(req_kind), 32'(req_funct3), req_alt, 32'(req_rd),
                              32'(req_rs1), 32'(req_rs2), req_imm));
      end
   endtask

   // Every cycle: check outputs against the model, then advance it for the coming edge.
   always @(negedge clk) begin
      int cnt;
      bit rdy;
      if (!rst_n) begin
         chk("rst_req_ready", 64'(req_ready), 64'd0);
         chk("rst_insn_valid", 64'(insn_valid), 64'd0);
         chk("rst_insn_out", 64'({insn_illegal, insn_data}), 64'd0);
         expq.delete();
         pend = 1'b0;
      end else begin
         cnt = expq.size() - (pend ? 1 : 0);
         rdy = !pend && (cnt < DEPTH);
         chk("req_ready", 64'(req_ready), 64'(rdy));
         chk("insn_valid", 64'(insn_valid), 64'(cnt > 0));
         if (cnt > 0) chk("head", 64'({insn_illegal, insn_data}), 64'(expq[0]));
         else         chk("empty_out", 64'({insn_illegal, insn_data}), 64'd0);
         if (cnt > 0 && insn_ready) void'(expq.pop_front());
         if (pend && cnt < DEPTH) pend = 1'b0;
         if (req_valid && rdy) m_accept();
      end
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int kind, input int f3, input bit alt, input int rd,
                       input int rs1, input int rs2, input logic [31:0] imm);
      int   n;
      logic ok;
      n = 0;
      req_kind = 4'(kind); req_funct3 = 3'(f3); req_alt = alt;
      req_rd = 5'(rd); req_rs1 = 5'(rs1); req_rs2 = 5'(rs2); req_imm = imm;
      req_valid = 1'b1;
      do begin
         @(negedge clk);
         ok = req_ready;
         sync();
         n++;
      end while (!ok && n < 50);
      req_valid = 1'b0;
      chk("send_accept", 64'(ok), 64'd1);
   endtask

   task automatic rand_req();
      req_valid  = ($urandom_range(0, 3) != 0);
      insn_ready = ($urandom_range(0, 2) != 0);
      req_kind   = 4'($urandom_range(0, 11));
      req_funct3 = 3'($urandom_range(0, 7));
      req_alt    = ($urandom_range(0, 3) == 0);
      req_rd     = 5'($urandom);
      req_rs1    = 5'($urandom);
      req_rs2    = 5'($urandom);
      case ($urandom_range(0, 4))
         0: req_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
         1: req_imm = $urandom & 32'hFFFF_F000;
         2: req_imm = $urandom;
         3: req_imm = 32'($urandom_range(0, 40));
         default: req_imm = ($urandom & 32'h001F_FFFE) - 32'h0010_0000;
      endcase
   endtask

   initial begin
      logic [31:0] w0, w1;
      bit          two;

      // Model pins against hand-encoded words
      chk("pin_imm", 64'(m_enc(32'd7, 32'd0, 1'b0, 32'd1, 32'd0, 32'd0, 32'd5)), 64'h0_0050_0093);
      chk("pin_sub", 64'(m_enc(32'd8, 32'd0, 1'b1, 32'd3, 32'd1, 32'd2, 32'd0)), 64'h0_4020_81B3);
      chk("pin_sw", 64'(m_enc(32'd6, 32'd2, 1'b0, 32'd0, 32'd1, 32'd2, 32'd8)), 64'h0_0020_A423);
      chk("pin_br_odd", 64'(m_enc(32'd4, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd3)), 64'h1_0000_0000);
      chk("pin_ld_f3", 64'(m_enc(32'd5, 32'd3, 1'b0, 32'd1, 32'd0, 32'd0, 32'd0)), 64'h1_0000_0000);
      chk("pin_kind12", 64'(m_enc(32'd12, 32'd0, 1'b0, 32'd1, 32'd0, 32'd0, 32'd0)), 64'h1_0000_0000);
      chk("pin_imm_alt", 64'(m_enc(32'd7, 32'd0, 1'b1, 32'd1, 32'd0, 32'd0, 32'd0)), 64'h1_0000_0000);
      m_li(32'd5, 32'h1234_5678, w0, w1, two);
      chk("pin_li_a", {w0, w1}, 64'h1234_52B7_6782_8293);
      m_li(32'd1, 32'h0000_0800, w0, w1, two);
      chk("pin_li_b", {w0, w1}, 64'h0000_10B7_8000_8093);
      m_li(32'd1, 32'h0000_1000, w0, w1, two);
      chk("pin_li_c", {w0, 31'd0, two}, 64'h0000_10B7_0000_0000);

      repeat (3) sync();
      rst_n = 1'b1;
      sync();

      // Fill the FIFO with a stalled consumer, then pop one entry
      send(7, 0, 1'b0, 1, 0, 0, 32'd5);
      @(negedge clk);
      chk("lit_addi", 64'({insn_valid, insn_illegal, insn_data}), 64'h2_0050_0093);
      sync();
      send(8, 0, 1'b1, 3, 1, 2, 32'd0);
      send(6, 2, 1'b0, 0, 1, 2, 32'd8);
      send(4, 0, 1'b0, 0, 0, 0, 32'd3);
      @(negedge clk);
      chk("lit_full_rdy", 64'(req_ready), 64'd0);
      sync();
      insn_ready = 1'b1;
      sync();
      insn_ready = 1'b0;
      @(negedge clk);
      chk("lit_pop_rdy", 64'(req_ready), 64'd1);
      chk("lit_head2", 64'(insn_data), 64'h4020_81B3);
      sync();
      insn_ready = 1'b1;
      repeat (5) sync();

      // LI expansions and illegal requests with a free-running consumer
      send(9, 0, 1'b0, 5, 0, 0, 32'h1234_5678);
      @(negedge clk);
      chk("lit_li2_rdy", 64'(req_ready), 64'd0);
      sync();
      send(9, 0, 1'b0, 1, 0, 0, 32'h0000_0800);
      send(9, 0, 1'b0, 1, 0, 0, 32'h0000_1000);
      send(5, 3, 1'b0, 1, 0, 0, 32'd0);
      send(12, 0, 1'b0, 1, 0, 0, 32'd0);
      send(7, 0, 1'b1, 1, 0, 0, 32'd0);
      repeat (4) sync();

      // LI whose LUI fills the FIFO, then reset while the ADDI is held
      insn_ready = 1'b0;
      send(7, 0, 1'b0, 1, 0, 0, 32'd1);
      send(7, 0, 1'b0, 2, 0, 0, 32'd2);
      send(7, 0, 1'b0, 3, 0, 0, 32'd3);
      send(9, 0, 1'b0, 5, 0, 0, 32'h1234_5678);
      @(negedge clk);
      chk("lit_li2_full", 64'({req_ready, insn_valid}), 64'd1);
      sync();
      rst_n = 1'b0;
      sync();
      sync();
      rst_n = 1'b1;
      insn_ready = 1'b1;
      repeat (6) sync();
      @(negedge clk);
      chk("lit_no_addi", 64'(insn_valid), 64'd0);
      sync();

      // Random traffic
      repeat (3000) begin
         rand_req();
         sync();
      end
      req_valid = 1'b0;
      insn_ready = 1'b1;
      repeat (12) sync();
      @(negedge clk);
      chk("drained", 64'(insn_valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
